// File: rtl/mam_sram_responder_if.sv
// MAM memory-side bundle: request channel, write beat channel, read beat channel, busy flag.
// master = request issuer, slave = memory responder.
interface mam_sram_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_burst;
  logic [13:0]             req_beats;
  logic                    write_valid;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_strb;
  logic                    write_ready;
  logic                    read_valid;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_ready;
  logic                    busy;

  modport master (
    output req_valid, req_rw, req_addr, req_burst, req_beats,
    output write_valid, write_data, write_strb, read_ready,
    input  req_ready, write_ready, read_valid, read_data, busy
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_burst, req_beats,
    input  write_valid, write_data, write_strb, read_ready,
    output req_ready, write_ready, read_valid, read_data, busy
  );
endinterface

// File: rtl/mam_sram_responder.sv
// MAM memory responder over an internal word-wide RAM; single/burst reads and byte-strobed writes.
// Optional MAM_RESP_WAIT_STATES_EN inserts WAIT_CYCLES stall cycles before each write beat and each read fetch.
module mam_sram_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  mam_sram_responder_if.slave bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int ALSB = $clog2(NB);
  localparam int MW   = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD_FETCH, S_RD_DATA} state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_write_ready;
  logic                  r_read_valid;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic [MW-1:0]         r_waddr;
  logic [13:0]           r_count;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic                  w_accept;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_last;
  logic [13:0]           w_beats;
  logic                  w_wait_done;
  logic                  w_wait_expiring;
  logic                  w_unused;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid && r_req_ready;
  assign w_wr_fire = (r_state == S_WRITE) && bus.write_valid && r_write_ready;
  assign w_rd_fire = r_read_valid && bus.read_ready;
  assign w_last    = (r_count == 14'd1);
  assign w_beats   = (!bus.req_burst || bus.req_beats == 14'd0) ? 14'd1 : bus.req_beats;
  assign w_unused  = ^{bus.req_addr, 32'(WAIT_CYCLES)};

`ifdef MAM_RESP_WAIT_STATES_EN
  localparam bit WAIT_EN = 1'b1;
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_CYCLES);

  logic [WW-1:0] r_wait;

  assign w_wait_done     = (r_wait == '0);
  assign w_wait_expiring = (r_wait == WW'(1));

  // Reloaded at every point where a new beat must be preceded by stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if (w_accept || w_wr_fire || w_rd_fire) begin
      r_wait <= WAIT_LOAD;
    end else if (!w_wait_done) begin
      r_wait <= r_wait - WW'(1);
    end
  end
`else
  localparam bit WAIT_EN = 1'b0;

  assign w_wait_done     = 1'b1;
  assign w_wait_expiring = 1'b0;
`endif

  // RAM has no reset so that contents survive a mid-burst abort.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.write_strb[i]) r_mem[r_waddr][8*i +: 8] <= bus.write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_req_ready   <= 1'b1;
      r_write_ready <= 1'b0;
      r_read_valid  <= 1'b0;
      r_read_data   <= '0;
      r_busy        <= 1'b0;
      r_waddr       <= '0;
      r_count       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_waddr     <= bus.req_addr[ALSB +: MW];
            r_count     <= w_beats;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.req_rw) begin
              r_state       <= S_WRITE;
              r_write_ready <= !WAIT_EN;
            end else begin
              r_state <= S_RD_FETCH;
            end
          end
        end
        S_WRITE: begin
          if (w_wr_fire) begin
            r_waddr <= r_waddr + MW'(1);
            r_count <= r_count - 14'd1;
            if (w_last) begin
              r_state       <= S_IDLE;
              r_write_ready <= 1'b0;
              r_req_ready   <= 1'b1;
              r_busy        <= 1'b0;
            end else begin
              r_write_ready <= !WAIT_EN;
            end
          end else if (w_wait_expiring) begin
            r_write_ready <= 1'b1;
          end
        end
        S_RD_FETCH: begin
          if (w_wait_done) begin
            r_read_data  <= r_mem[r_waddr];
            r_read_valid <= 1'b1;
            r_state      <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_rd_fire) begin
            r_read_valid <= 1'b0;
            r_waddr      <= r_waddr + MW'(1);
            r_count      <= r_count - 14'd1;
            if (w_last) begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state <= S_RD_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.write_ready = r_write_ready;
  assign bus.read_valid  = r_read_valid;
  assign bus.read_data   = r_read_data;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_mam_sram_responder.sv
// Directed bench for mam_sram_responder: strobed writes, bursts, stalls, address wrap/alias, mid-burst reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mam_sram_responder;
`ifdef MAM_RESP_WAIT_STATES_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif
  localparam int LAT = 2 + WS;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] wdat [8];
  logic [15:0] rexp [8];

  mam_sram_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) bus ();

  mam_sram_responder #(
    .DATA_WIDTH(16), .ADDR_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after acceptance.
  task automatic issue(input logic rw, input logic [31:0] addr, input logic burst,
                       input logic [13:0] beats);
    int k;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_burst = burst;
    bus.req_beats = beats;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wr_beats(input int n, input logic [1:0] strb);
    int stall;
    for (int i = 0; i < n; i++) begin
      bus.write_valid = 1'b1;
      bus.write_data  = wdat[i];
      bus.write_strb  = strb;
      stall = 0;
      while (!bus.write_ready && stall < 50) begin
        @(negedge clk);
        stall++;
      end
      chk("wr_stall", 32'(stall), 32'(WS));
      @(posedge clk);
      @(negedge clk);
    end
    bus.write_valid = 1'b0;
  endtask

  task automatic rd_beats(input int n, input int hold);
    int k;
    logic [15:0] cap;
    for (int i = 0; i < n; i++) begin
      k = 1;
      while (!bus.read_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("rd_latency", 32'(k), 32'(LAT));
      cap = bus.read_data;
      for (int s = 0; s < hold; s++) begin
        @(negedge clk);
        chk("rd_hold_valid", 32'(bus.read_valid), 32'd1);
        chk("rd_hold_data", 32'(bus.read_data), 32'(cap));
      end
      chk("rd_data", 32'(cap), 32'(rexp[i]));
      bus.read_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.read_ready = 1'b0;
    end
    chk("rd_done_valid", 32'(bus.read_valid), 32'd0);
    chk("rd_done_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_rw      = 1'b0;
    bus.req_addr    = '0;
    bus.req_burst   = 1'b0;
    bus.req_beats   = '0;
    bus.write_valid = 1'b0;
    bus.write_data  = '0;
    bus.write_strb  = '0;
    bus.read_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_write_ready", 32'(bus.write_ready), 32'd0);
    chk("rst_read_valid", 32'(bus.read_valid), 32'd0);
    chk("rst_read_data", 32'(bus.read_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single write then single read
    issue(1'b1, 32'h0, 1'b0, 14'd0);
    chk("t1_busy_wr", 32'(bus.busy), 32'd1);
    wdat[0] = 16'h000F;
    wr_beats(1, 2'b11);
    issue(1'b0, 32'h0, 1'b0, 14'd0);
    rexp[0] = 16'h000F;
    rd_beats(1, 0);

    // 2: 7-beat burst write and read
    issue(1'b1, 32'h0, 1'b1, 14'd7);
    for (int i = 0; i < 7; i++) wdat[i] = 16'(i);
    wr_beats(7, 2'b11);
    issue(1'b0, 32'h0, 1'b1, 14'd7);
    for (int i = 0; i < 7; i++) rexp[i] = 16'(i);
    rd_beats(7, 0);

    // 3: low-byte-only strobe merges into existing word
    issue(1'b1, 32'h4, 1'b0, 14'd0);
    wdat[0] = 16'hFFFF;
    wr_beats(1, 2'b11);
    issue(1'b1, 32'h4, 1'b0, 14'd0);
    wdat[0] = 16'h1234;
    wr_beats(1, 2'b01);
    issue(1'b0, 32'h4, 1'b0, 14'd0);
    rexp[0] = 16'hFF34;
    rd_beats(1, 0);

    // 4: 3-beat read with 5 stalled cycles per beat
    issue(1'b0, 32'h0, 1'b1, 14'd3);
    rexp[0] = 16'h0000;
    rexp[1] = 16'h0001;
    rexp[2] = 16'hFF34;
    rd_beats(3, 5);

    // 5: burst wraps from the last word to word 0; high address bits alias
    issue(1'b1, 32'h7FE, 1'b1, 14'd3);
    wdat[0] = 16'hC0DE;
    wdat[1] = 16'hC1DE;
    wdat[2] = 16'hC2DE;
    wr_beats(3, 2'b11);
    issue(1'b0, 32'h7FE, 1'b1, 14'd3);
    rexp[0] = 16'hC0DE;
    rexp[1] = 16'hC1DE;
    rexp[2] = 16'hC2DE;
    rd_beats(3, 0);
    issue(1'b0, 32'h0000_0800, 1'b0, 14'd5);
    rexp[0] = 16'hC1DE;
    rd_beats(1, 0);
    issue(1'b0, 32'h7FE, 1'b1, 14'd0);
    rexp[0] = 16'hC0DE;
    rd_beats(1, 0);

    // 6: reset after beat 2 of a 6-beat write
    issue(1'b1, 32'h100, 1'b1, 14'd6);
    wdat[0] = 16'hA001;
    wdat[1] = 16'hA002;
    wr_beats(2, 2'b11);
    bus.write_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.write_valid = 1'b0;
    chk("t6_req_ready", 32'(bus.req_ready), 32'd1);
    chk("t6_write_ready", 32'(bus.write_ready), 32'd0);
    chk("t6_read_valid", 32'(bus.read_valid), 32'd0);
    chk("t6_read_data", 32'(bus.read_data), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h100, 1'b1, 14'd2);
    rexp[0] = 16'hA001;
    rexp[1] = 16'hA002;
    rd_beats(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
